cosim_compare: RTL
==================

COSIM_COMPARE -- requirements
Module: cosim_compare

Interface
REQ-001 Parameter DEPTH, default 8, per-channel commit FIFO entries; power of two, 2..64.
REQ-002 Parameter TIMEOUT, default 1024, max cycles one channel may lead the other before timeout.
REQ-003 Parameter CHK_WB, default 1, enables rd/wdata comparison.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en  in  1  comparison enable; 0 freezes pops and watchdog, pushes still accepted.
REQ-007 dut_valid, ref_valid  in  1  commit record valid per channel.
REQ-008 dut_rec, ref_rec  in  commit_rec_t  {pc XLEN, instr 32, wb_en 1, rd 5, wdata XLEN}.
REQ-009 dut_ready, ref_ready  out  1  channel FIFO not full.
REQ-010 mismatch  out  1  sticky compare failure.
REQ-011 timeout  out  1  sticky watchdog expiry.
REQ-012 overflow  out  1  sticky push-while-full on either channel.
REQ-013 halt  out  1  OR of mismatch, timeout, overflow; drives core kill.
REQ-014 match_cnt  out  32  count of matched record pairs.
REQ-015 fail_pc  out  XLEN  dut pc of first failing pair; 0 otherwise.

Function
REQ-016 Push: record written when valid && ready; ready = registered count < DEPTH; ready is not raised by a same-cycle pop.
REQ-017 valid && !ready drops the record and sets overflow next cycle.
REQ-018 FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty come from MSB compare.
REQ-019 Pop: in RUN with en=1 and both FIFOs non-empty, pop one record from each in the same cycle.
REQ-020 Compare fields: pc, instr, wb_en always; with CHK_WB=1 and wb_en=1 and rd!=0, also rd and wdata.
REQ-021 Compare result is registered; mismatch asserts exactly one cycle after the pop cycle; match_cnt increments in that same cycle on match.
REQ-022 match_cnt saturates at 32'hFFFF_FFFF.
REQ-023 FSM states RUN, FAIL, TOUT: RUN->FAIL on mismatch or overflow; RUN->TOUT on watchdog expiry; FAIL and TOUT held until rst.
REQ-024 If mismatch and timeout occur in the same cycle, FAIL wins; timeout stays 0.
REQ-025 Watchdog counts cycles in RUN with en=1 where exactly one FIFO is non-empty; clears on any pop or when both FIFOs are empty; expiry when count == TIMEOUT-1.
REQ-026 In FAIL/TOUT: no pops, pushes still accepted until full, outputs frozen except ready.
REQ-027 fail_pc latched only on the RUN->FAIL transition caused by mismatch.

Reset
REQ-028 On rst: FIFOs empty, pointers 0, state RUN, watchdog 0, match_cnt 0, fail_pc 0; mismatch, timeout, overflow, halt 0; dut_ready and ref_ready 1 the cycle after rst deasserts.
REQ-029 rst asserted mid-operation discards all queued records and sticky flags within one cycle.

Structure
REQ-030 commit_rec_t and the cmp_state_t enum are defined in package defines; XLEN comes from defines.
REQ-031 One sub-module, commit_fifo (params DEPTH, type T), instantiated twice.
REQ-032 Total RTL size is 150-300 lines.

Verification
REQ-033 Identical streams: 100 records pc 0x10000+4i pushed to both channels with random skew <8 -> match_cnt=100, halt=0.
REQ-034 Corruption: record 37 on ref has wdata XOR 1 with wb_en=1, rd=5 -> mismatch=1 one cycle after pair 37 pops, fail_pc=0x10094, match_cnt=37.
REQ-035 Mask check: CHK_WB=1, rd=0, wdata differs -> no mismatch.
REQ-036 Watchdog: TIMEOUT=16, dut pushes 1 record, ref silent -> timeout=1 after 16 cycles, halt=1, mismatch=0.
REQ-037 Overflow and wrap: DEPTH=4, 5 dut pushes with ref silent and en=0 -> dut_ready=0 after the 4th push, overflow=1; separately, 3*DEPTH balanced pushes -> pointers wrap, no error.
REQ-038 Reset mid-run: rst pulsed with 3 records queued -> next cycle all counters and flags 0, ready=1, first subsequent pair compared correctly.

Source files
------------

// File: rtl/defines.sv
// Shared record/state types and the pairwise compare rule for the commit-stream
// co-simulation checker.
package defines;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            wb_en;
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
    } commit_rec_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        FAIL = 2'd1,
        TOUT = 2'd2
    } cmp_state_t;

    // Writes to x0 carry no architectural state, so rd/wdata are only checked for live writebacks.
    function automatic logic rec_mismatch(input commit_rec_t d, input commit_rec_t r,
                                          input logic chk_wb);
        logic wb_live;
        wb_live = chk_wb && d.wb_en && (d.rd != 5'd0);
        return (d.pc != r.pc) || (d.instr != r.instr) || (d.wb_en != r.wb_en) ||
               (wb_live && ((d.rd != r.rd) || (d.wdata != r.wdata)));
    endfunction

endpackage

// File: rtl/commit_fifo.sv
// Per-channel commit FIFO; pointers carry one extra wrap bit so full/empty
// fall out of a plain pointer compare.
module commit_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cosim_compare.sv
// Lockstep checker: queues dut/ref commit records, pops them in pairs and
// raises a sticky halt on mismatch, overflow or a one-sided stall.
module cosim_compare
    import defines::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024,
    parameter int CHK_WB  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            dut_valid,
    input  commit_rec_t     dut_rec,
    input  logic            ref_valid,
    input  commit_rec_t     ref_rec,
    output logic            dut_ready,
    output logic            ref_ready,
    output logic            mismatch,
    output logic            timeout,
    output logic            overflow,
    output logic            halt,
    output logic [31:0]     match_cnt,
    output logic [XLEN-1:0] fail_pc
);

    localparam int NCH = 2;
    localparam int WDW = $clog2(TIMEOUT) + 1;

    // Channel 0 is the dut stream, channel 1 the reference stream.
    logic        [NCH-1:0] ch_valid;
    logic        [NCH-1:0] ch_full;
    logic        [NCH-1:0] ch_empty;
    logic        [NCH-1:0] ch_push;
    logic        [NCH-1:0] ch_drop;
    commit_rec_t [NCH-1:0] ch_rec;
    commit_rec_t [NCH-1:0] ch_head;

    cmp_state_t     state;
    logic [WDW-1:0] wdog;
    logic           pop;
    logic           pair_bad;
    logic           one_busy;

    assign ch_valid = {ref_valid, dut_valid};
    assign ch_rec   = {ref_rec, dut_rec};
    assign ch_push  = ch_valid & ~ch_full;
    assign ch_drop  = ch_valid & ch_full;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        commit_fifo #(
            .DEPTH (DEPTH),
            .T     (commit_rec_t)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (ch_push[c]),
            .din   (ch_rec[c]),
            .pop   (pop),
            .dout  (ch_head[c]),
            .full  (ch_full[c]),
            .empty (ch_empty[c])
        );
    end

    assign dut_ready = !ch_full[0];
    assign ref_ready = !ch_full[1];
    assign pop       = (state == RUN) && en && (ch_empty == '0);
    assign pair_bad  = rec_mismatch(ch_head[0], ch_head[1], CHK_WB != 0);
    assign one_busy  = ch_empty[0] ^ ch_empty[1];
    assign halt      = mismatch | timeout | overflow;

    // Failure causes are checked before the watchdog so a compare failure always wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wdog      <= '0;
            match_cnt <= '0;
            fail_pc   <= '0;
            mismatch  <= 1'b0;
            timeout   <= 1'b0;
            overflow  <= 1'b0;
        end else if (state == RUN) begin
            if (pop && pair_bad) begin
                mismatch <= 1'b1;
                fail_pc  <= ch_head[0].pc;
            end else if (pop && match_cnt != '1) begin
                match_cnt <= match_cnt + 32'd1;
            end
            if (|ch_drop)
                overflow <= 1'b1;

            if ((pop && pair_bad) || (|ch_drop)) begin
                state <= FAIL;
            end else if (en) begin
                if (pop || (ch_empty == '1)) begin
                    wdog <= '0;
                end else if (one_busy && wdog == WDW'(TIMEOUT - 1)) begin
                    timeout <= 1'b1;
                    state   <= TOUT;
                end else if (one_busy) begin
                    wdog <= wdog + 1'b1;
                end
            end
        end
    end

endmodule
